twowire_apb_splitter: RTL
=========================

# twowire_apb_splitter

Registered APB3 address decoder and fan-out that sits directly downstream of the Two-Wire Debug DTM core's `dst_*` bus port. It accepts one upstream transfer at a time and decodes the address against `N_SLAVES` base/mask regions. The transfer is replayed on the selected downstream slave port, and the response is returned upstream. Unmapped addresses and stalled slaves complete upstream with `s_pslverr=1`, so the DTM records a bus fault and never hangs.

## Interface
Parameters:
- `W_ADDR`, 8: address width; must equal the DTM's `8*(1+ASIZE)`.
- `N_SLAVES`, 2: number of downstream ports, 1..16.
- `SLAVE_BASE`, `{N_SLAVES{W_ADDR'h0}}`: packed bases; slave i occupies `[W_ADDR*i +: W_ADDR]`.
- `SLAVE_MASK`, `{N_SLAVES{W_ADDR'h0}}`: packed masks with the same packing; slave i matches when `(addr & MASK_i) == BASE_i`.
- `TIMEOUT`, 255: maximum number of ACCESS cycles before abort; 0 disables the timeout.
- `W_TOCTR`, 8: timeout counter width; requires `TIMEOUT < 2**W_TOCTR`.

Ports:
- `dck` input 1: clock. This is the block's only clock.
- `drst_n` input 1: reset, synchronous and active-low, sampled on the rising edge of `dck`.
- `s_paddr` input W_ADDR: upstream address.
- `s_psel` input 1: upstream select.
- `s_penable` input 1: upstream enable.
- `s_pwrite` input 1: upstream write flag.
- `s_pwdata` input 32: upstream write data.
- `s_pready` output 1: upstream ready.
- `s_pslverr` output 1: upstream error.
- `s_prdata` output 32: upstream read data.
- `m_paddr` output W_ADDR: downstream address, shared by all slaves.
- `m_psel` output N_SLAVES: one-hot downstream select.
- `m_penable` output 1: downstream enable, shared by all slaves.
- `m_pwrite` output 1: downstream write flag, shared.
- `m_pwdata` output 32: downstream write data, shared.
- `m_pready` input N_SLAVES: per-slave ready.
- `m_pslverr` input N_SLAVES: per-slave error.
- `m_prdata` input 32*N_SLAVES: per-slave read data; slave i drives `[32*i +: 32]`.
- `timeout_evt` output 1: one-cycle pulse on every timeout abort.

## Operation
- The state machine has four states: IDLE, SETUP, ACCESS, RESP. The encoding is free.
- **IDLE.** On `s_psel && !s_penable`:
  - Latch `s_paddr`, `s_pwrite` and `s_pwdata` into `m_paddr`, `m_pwrite` and `m_pwdata`.
  - Decode the address. If several regions overlap, the lowest matching index wins.
  - On a hit, latch the one-hot index and go to SETUP.
  - On a miss, set `s_pslverr=1` and `s_prdata=0`, and go to RESP.
  - With no upstream setup, stay in IDLE.
- **SETUP.**
  - Drives `m_psel[idx]=1` and `m_penable=0`.
  - Clears the timeout counter.
  - Always goes to ACCESS on the next cycle.
- **ACCESS.**
  - Drives `m_psel[idx]=1` and `m_penable=1`.
  - Only `m_pready[idx]`, `m_pslverr[idx]` and the idx lane of `m_prdata` are observed.
  - On `m_pready[idx]`: capture the idx lane of `m_prdata` into `s_prdata` (captured for writes too) and `m_pslverr[idx]` into `s_pslverr`, then go to RESP.
  - Otherwise, if `TIMEOUT != 0` and the counter equals `TIMEOUT-1`, abort:
    - deassert `m_psel` and `m_penable` on the next cycle;
    - set `s_pslverr=1` and `s_prdata=0`;
    - pulse `timeout_evt` in the first RESP cycle;
    - go to RESP.
  - Otherwise, increment the counter.
  - If `m_pready` arrives in the same cycle the terminal count is reached, it is a normal completion, not a timeout.
- **RESP.**
  - Drives `s_pready=1` for exactly one cycle, then returns to IDLE.
  - All `m_psel` bits are 0.
- `s_pready` is 0 in every state other than RESP.
- `s_prdata` and `s_pslverr` hold their captured values until the next capture. They are meaningful only while `s_pready=1`.
- Upstream protocol and control:
  - The upstream master must hold the transfer stable until `s_pready`; the DTM core does this.
  - Upstream inputs are ignored outside IDLE.
  - The upstream error, not the splitter, controls whether the address auto-increments.
- `m_paddr`, `m_pwrite` and `m_pwdata` are stable from SETUP through ACCESS. They keep their last value in IDLE and RESP.

## Timing
- Reset: synchronous, active-low.
  - State returns to IDLE.
  - `s_pready`, `s_pslverr`, `s_prdata`, `m_psel`, `m_penable`, `m_pwrite`, `m_paddr`, `m_pwdata`, `timeout_evt` and the counter are all 0.
  - Asserting reset mid-transfer drops `m_psel` and `m_penable` on the next edge. No response is generated.
- All outputs are registered; there are no combinational input-to-output paths.
- Mapped transfer to a zero-wait slave, with upstream setup at cycle T0:
  - SETUP at T1, ACCESS at T2 (`m_pready=1`), RESP at T3 (`s_pready=1`).
  - The upstream transfer therefore lasts 4 cycles, versus 2 for a native APB transfer.
  - Each downstream wait state adds one cycle.
- Unmapped transfer: upstream setup at T0, RESP at T1. The upstream transfer lasts 2 cycles.
- Timeout: exactly `TIMEOUT` ACCESS cycles occur, then RESP.
- Back-to-back: a new upstream setup is accepted in the IDLE cycle immediately after RESP.

## Test plan
- **Mapped write.** Slave 0 at BASE=0x00, MASK=0xF0; slave 1 at BASE=0x10, MASK=0xF0. Write 0xDEADBEEF to 0x13.
  - `m_psel=2'b10` in SETUP and ACCESS, with `m_pwdata=0xDEADBEEF` and `m_paddr=0x13`.
  - `s_pready` rises 3 cycles after upstream setup; `s_pslverr=0`.
- **Read with wait states.** Read 0x05; slave 0 returns 0x12345678 after 3 wait states.
  - `s_prdata=0x12345678` with `s_pready`, 6 cycles after upstream setup.
  - `m_psel[1]` stays 0 throughout.
- **Unmapped.** Read 0x80.
  - No `m_psel` bit is asserted.
  - `s_pready=1`, `s_pslverr=1`, `s_prdata=0` one cycle after setup.
- **Timeout.** TIMEOUT=4; the slave never readies.
  - Exactly 4 ACCESS cycles, then `m_psel` and `m_penable` go to 0.
  - `timeout_evt` pulses once.
  - `s_pslverr=1` with `s_pready`.
  - Edge case: with pready in the 4th ACCESS cycle, the transfer completes normally and there is no pulse.
- **Overlap and slave error.** Both slaves decode 0x00.
  - `m_psel=2'b01`, because the lowest index wins.
  - When slave 0 returns `m_pslverr=1`, `s_pslverr=1`.
- **Reset mid-ACCESS and back-to-back.**
  - Assert `drst_n=0` during ACCESS: all outputs are 0 on the next edge.
  - After release, two consecutive upstream transfers both complete with the correct data.

Source files
------------

// File: rtl/twowire_apb_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | twowire_apb_splitter: registered APB3 decoder/fan-out behind the DTM.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module twowire_apb_splitter #(
  parameter int                         W_ADDR     = 8,
  parameter int                         N_SLAVES   = 2,
  parameter logic [N_SLAVES*W_ADDR-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*W_ADDR-1:0] SLAVE_MASK = '0,
  parameter int                         TIMEOUT    = 255,
  parameter int                         W_TOCTR    = 8
) (
  input  logic                   dck,
  input  logic                   drst_n,
  input  logic [W_ADDR-1:0]      s_paddr,
  input  logic                   s_psel,
  input  logic                   s_penable,
  input  logic                   s_pwrite,
  input  logic [31:0]            s_pwdata,
  output logic                   s_pready,
  output logic                   s_pslverr,
  output logic [31:0]            s_prdata,
  output logic [W_ADDR-1:0]      m_paddr,
  output logic [N_SLAVES-1:0]    m_psel,
  output logic                   m_penable,
  output logic                   m_pwrite,
  output logic [31:0]            m_pwdata,
  input  logic [N_SLAVES-1:0]    m_pready,
  input  logic [N_SLAVES-1:0]    m_pslverr,
  input  logic [32*N_SLAVES-1:0] m_prdata,
  output logic                   timeout_evt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam bit                 c_to_en   = (TIMEOUT != 0);
  localparam logic [W_TOCTR-1:0] c_to_last = W_TOCTR'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [N_SLAVES-1:0] m_psel_q, m_psel_d;
  logic                m_penable_q, m_penable_d;
  logic [W_ADDR-1:0]   m_paddr_q, m_paddr_d;
  logic                m_pwrite_q, m_pwrite_d;
  logic [31:0]         m_pwdata_q, m_pwdata_d;
  logic                s_pready_q, s_pready_d;
  logic                s_pslverr_q, s_pslverr_d;
  logic [31:0]         s_prdata_q, s_prdata_d;
  logic                timeout_evt_q, timeout_evt_d;
  logic [W_TOCTR-1:0]  cnt_q, cnt_d;

  logic                w_dec_hit;
  logic [N_SLAVES-1:0] w_dec_sel;
  logic                w_sel_rdy;
  logic                w_sel_err;
  logic [31:0]         w_sel_rdata;

  // Priority decode: the first matching region claims the address.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!w_dec_hit &&
          ((s_paddr & SLAVE_MASK[W_ADDR*i +: W_ADDR]) == SLAVE_BASE[W_ADDR*i +: W_ADDR])) begin
        w_dec_sel[i] = 1'b1;
        w_dec_hit    = 1'b1;
      end
    end
  end

  // The latched one-hot select doubles as the response lane select.
  always_comb begin
    w_sel_rdy   = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (m_psel_q[i]) begin
        w_sel_rdy   = w_sel_rdy | m_pready[i];
        w_sel_err   = w_sel_err | m_pslverr[i];
        w_sel_rdata = w_sel_rdata | m_prdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    m_psel_d      = m_psel_q;
    m_penable_d   = m_penable_q;
    m_paddr_d     = m_paddr_q;
    m_pwrite_d    = m_pwrite_q;
    m_pwdata_d    = m_pwdata_q;
    s_pready_d    = 1'b0;
    s_pslverr_d   = s_pslverr_q;
    s_prdata_d    = s_prdata_q;
    timeout_evt_d = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (s_psel && !s_penable) begin
          m_paddr_d  = s_paddr;
          m_pwrite_d = s_pwrite;
          m_pwdata_d = s_pwdata;
          if (w_dec_hit) begin
            m_psel_d = w_dec_sel;
            state_d  = ST_SETUP;
          end else begin
            s_pslverr_d = 1'b1;
            s_prdata_d  = '0;
            s_pready_d  = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        cnt_d       = '0;
        m_penable_d = 1'b1;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready on the terminal count wins over the abort.
        if (w_sel_rdy) begin
          s_prdata_d  = w_sel_rdata;
          s_pslverr_d = w_sel_err;
          s_pready_d  = 1'b1;
          m_psel_d    = '0;
          m_penable_d = 1'b0;
          state_d     = ST_RESP;
        end else if (c_to_en && (cnt_q == c_to_last)) begin
          s_prdata_d    = '0;
          s_pslverr_d   = 1'b1;
          s_pready_d    = 1'b1;
          timeout_evt_d = 1'b1;
          m_psel_d      = '0;
          m_penable_d   = 1'b0;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + W_TOCTR'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge dck) begin
    if (!drst_n) begin
      state_q       <= ST_IDLE;
      m_psel_q      <= '0;
      m_penable_q   <= 1'b0;
      m_paddr_q     <= '0;
      m_pwrite_q    <= 1'b0;
      m_pwdata_q    <= '0;
      s_pready_q    <= 1'b0;
      s_pslverr_q   <= 1'b0;
      s_prdata_q    <= '0;
      timeout_evt_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      m_psel_q      <= m_psel_d;
      m_penable_q   <= m_penable_d;
      m_paddr_q     <= m_paddr_d;
      m_pwrite_q    <= m_pwrite_d;
      m_pwdata_q    <= m_pwdata_d;
      s_pready_q    <= s_pready_d;
      s_pslverr_q   <= s_pslverr_d;
      s_prdata_q    <= s_prdata_d;
      timeout_evt_q <= timeout_evt_d;
      cnt_q         <= cnt_d;
    end
  end

  assign s_pready    = s_pready_q;
  assign s_pslverr   = s_pslverr_q;
  assign s_prdata    = s_prdata_q;
  assign m_paddr     = m_paddr_q;
  assign m_psel      = m_psel_q;
  assign m_penable   = m_penable_q;
  assign m_pwrite    = m_pwrite_q;
  assign m_pwdata    = m_pwdata_q;
  assign timeout_evt = timeout_evt_q;

endmodule
`default_nettype wire
